// File: rtl/pipe_scheduler.sv
// Game sequencer: IDLE/RUN/DEAD play FSM, pipe scroll position, per-lap gap height from a free-running LFSR, score.
// All outputs registered; one clk from input to output, no backpressure (Collision/Button sampled every clk).
module pipe_scheduler #(
    parameter int          SCREEN_W  = 640,
    parameter int          PIPE_W    = 90,
    parameter int          BIRD_X    = 160,
    parameter int          GAP_MIN   = 40,
    parameter int          GAP_MAX   = 240,
    parameter int          TICK_DIV  = 65536,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        Button,
    input  logic        Collision,
    output logic [15:0] PipesPosition,
    output logic [15:0] PipesLong,
    output logic        Status,
    output logic        ScoreInc,
    output logic [15:0] Score,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DEAD = 2'd2
    } state_t;

    localparam int          TW        = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [15:0] SCREEN_16 = 16'(SCREEN_W);
    localparam logic [15:0] SCORE_POS = 16'(BIRD_X - PIPE_W);
    localparam logic [15:0] GAP_MIN16 = 16'(GAP_MIN);
    localparam logic [15:0] GAP_MID16 = 16'((GAP_MIN + GAP_MAX) / 2);
    localparam logic [7:0]  RANGE8    = 8'(GAP_MAX - GAP_MIN);

    state_t          state_q;
    logic [15:0]     pos_q;
    logic [15:0]     len_q;
    logic [15:0]     score_q;
    logic [15:0]     lfsr_q;
    logic [15:0]     lfsr_d;
    logic [TW-1:0]   tick_q;
    logic            btn_q;
    logic            status_q;
    logic            inc_q;
    logic            press;
    logic [7:0]      gap_v;
    logic [15:0]     len_d;

    // Fibonacci taps 16,14,13,11 with a right shift: feedback enters at bit 15
    assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    assign press  = Button & ~btn_q;

    // Folding values above the range by 128 keeps the gap inside GAP_MIN..GAP_MAX
    assign gap_v  = (lfsr_q[7:0] > RANGE8) ? (lfsr_q[7:0] - 8'd128) : lfsr_q[7:0];
    assign len_d  = GAP_MIN16 + {8'd0, gap_v};

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            pos_q    <= SCREEN_16;
            len_q    <= GAP_MID16;
            score_q  <= 16'd0;
            inc_q    <= 1'b0;
            status_q <= 1'b0;
            tick_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            btn_q    <= 1'b0;
        end else begin
            btn_q   <= Button;
            lfsr_q  <= lfsr_d;
            inc_q   <= 1'b0;
            score_q <= score_q;
            case (state_q)
                S_IDLE: begin
                    if (press) begin
                        state_q  <= S_RUN;
                        status_q <= 1'b1;
                        tick_q   <= '0;
                    end
                end
                S_RUN: begin
                    if (Collision) begin
                        state_q  <= S_DEAD;
                        status_q <= 1'b0;
                    end else if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        if (pos_q == 16'd0) begin
                            pos_q <= SCREEN_16;
                            len_q <= len_d;
                        end else begin
                            pos_q <= pos_q - 16'd1;
                            if (pos_q == SCORE_POS) begin
                                inc_q <= 1'b1;
                                if (score_q != 16'hFFFF) begin
                                    score_q <= score_q + 16'd1;
                                end
                            end
                        end
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end
                S_DEAD: begin
                    if (press) begin
                        state_q <= S_IDLE;
                        pos_q   <= SCREEN_16;
                        score_q <= 16'd0;
                    end
                end
                default: begin
                    state_q  <= S_IDLE;
                    status_q <= 1'b0;
                end
            endcase
        end
    end

    assign PipesPosition = pos_q;
    assign PipesLong     = len_q;
    assign Status        = status_q;
    assign ScoreInc      = inc_q;
    assign Score         = score_q;
    assign State         = state_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler with a fast scroll tick; every clk is compared against a lap-level game model.
module tb_pipe_scheduler;

    localparam int TD = 4;

    logic        clk;
    logic        Reset;
    logic        Button;
    logic        Collision;
    logic [15:0] PipesPosition;
    logic [15:0] PipesLong;
    logic        Status;
    logic        ScoreInc;
    logic [15:0] Score;
    logic [1:0]  State;

    pipe_scheduler #(.TICK_DIV(TD)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .Button       (Button),
        .Collision    (Collision),
        .PipesPosition(PipesPosition),
        .PipesLong    (PipesLong),
        .Status       (Status),
        .ScoreInc     (ScoreInc),
        .Score        (Score),
        .State        (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference game state
    int          m_st;
    int          m_pos;
    int          m_len;
    int          m_score;
    int          m_inc;
    int          m_tick;
    logic [15:0] m_lfsr;
    logic        m_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            if (n_fail <= 30) $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int gap_of(input logic [15:0] l);
        int v;
        v = int'(l) % 256;
        if (v > 240 - 40) v = v - 128;
        return 40 + v;
    endfunction

    task model_update(input logic rst, input logic btn, input logic col);
        logic fb;
        if (rst) begin
            m_st = 0; m_pos = 640; m_len = 140; m_score = 0; m_inc = 0;
            m_tick = 0; m_lfsr = 16'hACE1; m_prev = 1'b0;
        end else begin
            m_inc = 0;
            if (m_st == 0) begin
                if (btn && !m_prev) begin m_st = 1; m_tick = 0; end
            end else if (m_st == 1) begin
                if (col) m_st = 2;
                else if (m_tick == TD - 1) begin
                    m_tick = 0;
                    if (m_pos == 0) begin
                        m_pos = 640;
                        m_len = gap_of(m_lfsr);
                    end else begin
                        if (m_pos == 160 - 90) begin
                            m_inc = 1;
                            m_score = (m_score >= 65535) ? 65535 : m_score + 1;
                        end
                        m_pos = m_pos - 1;
                    end
                end else m_tick = m_tick + 1;
            end else begin
                if (btn && !m_prev) begin m_st = 0; m_pos = 640; m_score = 0; end
            end
            fb = m_lfsr[16-16] ^ m_lfsr[16-14] ^ m_lfsr[16-13] ^ m_lfsr[16-11];
            m_lfsr = {fb, m_lfsr[15:1]};
            m_prev = btn;
        end
    endtask

    task automatic compare_all();
        chk("state",  32'(State),         m_st);
        chk("pos",    32'(PipesPosition), m_pos);
        chk("len",    32'(PipesLong),     m_len);
        chk("score",  32'(Score),         m_score);
        chk("inc",    32'(ScoreInc),      m_inc);
        chk("status", 32'(Status),        (m_st == 1) ? 1 : 0);
    endtask

    task automatic step_cyc(input logic rst, input logic btn, input logic col);
        @(negedge clk);
        Reset = rst; Button = btn; Collision = col;
        @(posedge clk);
        model_update(rst, btn, col);
        #1;
        compare_all();
    endtask

    // Run with random (ignored) button activity until a scroll step lands on target
    task automatic run_until(input int target, input int budget, input string tag);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step_cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            if (m_st == 1 && m_pos == target && m_tick == 0) begin
                hit = 1'b1;
                break;
            end
        end
        chk({tag, "_reached"}, 32'(hit), 1);
        chk({tag, "_pos"}, 32'(PipesPosition), target);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"},  32'(State), 0);
        chk({tag, "_pos"},    32'(PipesPosition), 640);
        chk({tag, "_len"},    32'(PipesLong), 140);
        chk({tag, "_score"},  32'(Score), 0);
        chk({tag, "_inc"},    32'(ScoreInc), 0);
        chk({tag, "_status"}, 32'(Status), 0);
    endtask

    initial begin
        Reset = 1'b1; Button = 1'b0; Collision = 1'b0;
        m_st = 0; m_pos = 640; m_len = 140; m_score = 0; m_inc = 0;
        m_tick = 0; m_lfsr = 16'hACE1; m_prev = 1'b0;

        for (int i = 0; i < 3; i++) step_cyc(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step_cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        chk_reset_vals("idle");

        step_cyc(1'b0, 1'b1, 1'b0);
        chk("start_state", 32'(State), 1);
        chk("start_status", 32'(Status), 1);
        for (int i = 0; i < 40; i++) step_cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        chk("pos_after_40", 32'(PipesPosition), 630);
        chk("run_ignores_press", 32'(State), 1);

        run_until(69, 3000, "first_pass");
        chk("first_pass_inc", 32'(ScoreInc), 1);
        chk("first_pass_score", 32'(Score), 1);
        step_cyc(1'b0, 1'b0, 1'b0);
        chk("first_pass_inc_clear", 32'(ScoreInc), 0);

        run_until(0, 1000, "lap_end");
        run_until(640, 10, "wrap");
        chk("wrap_len_model", 32'(PipesLong), m_len);
        chk("wrap_len_range", (PipesLong >= 16'd40 && PipesLong <= 16'd240) ? 32'd1 : 32'd0, 1);

        run_until(69, 3000, "second_pass");
        chk("second_pass_score", 32'(Score), 2);
        run_until(69, 3000, "third_pass");
        chk("third_pass_score", 32'(Score), 3);

        force dut.score_q = 16'hFFFE;
        m_score = 65534;
        step_cyc(1'b0, 1'b0, 1'b0);
        release dut.score_q;
        step_cyc(1'b0, 1'b0, 1'b0);
        chk("forced_score", 32'(Score), 32'hFFFE);
        run_until(69, 3000, "sat_pass1");
        chk("sat_pass1_score", 32'(Score), 32'hFFFF);
        run_until(69, 3000, "sat_pass2");
        chk("sat_pass2_score", 32'(Score), 32'hFFFF);
        chk("sat_pass2_inc", 32'(ScoreInc), 1);

        for (int i = 0; i < TD - 1; i++) step_cyc(1'b0, 1'b1, 1'b0);
        step_cyc(1'b0, 1'b1, 1'b1);
        chk("dead_state", 32'(State), 2);
        chk("dead_pos", 32'(PipesPosition), 69);
        chk("dead_inc", 32'(ScoreInc), 0);
        for (int i = 0; i < 10; i++) step_cyc(1'b0, 1'b1, 1'($urandom_range(0, 1)));
        chk("dead_held_button", 32'(State), 2);
        chk("dead_frozen_pos", 32'(PipesPosition), 69);
        step_cyc(1'b0, 1'b0, 1'b0);
        step_cyc(1'b0, 1'b1, 1'b0);
        chk("restart_state", 32'(State), 0);
        chk("restart_pos", 32'(PipesPosition), 640);
        chk("restart_score", 32'(Score), 0);

        step_cyc(1'b0, 1'b0, 1'b0);
        step_cyc(1'b0, 1'b1, 1'b0);
        chk("run_again", 32'(State), 1);
        run_until(300, 2000, "mid_run");
        step_cyc(1'b1, 1'b0, 1'b0);
        chk_reset_vals("rst_in_run");

        step_cyc(1'b0, 1'b0, 1'b0);
        step_cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) step_cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        step_cyc(1'b0, 1'b0, 1'b1);
        chk("dead_again", 32'(State), 2);
        step_cyc(1'b1, 1'b0, 1'b0);
        chk_reset_vals("rst_in_dead");
        for (int i = 0; i < 20; i++) step_cyc(1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
